// File: rtl/cpu_bus_arbiter.sv
// Turns a diagnostics halt request into a phi2-aligned CPU RDY stall. The memory bus is handed to
// the diagnostics port only after the CPU is provably stalled, and is returned before RDY rises.
module cpu_bus_arbiter #(
    parameter int SETTLE_EDGES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        fpga_clk,
    input  logic        fpga_reset,
    input  logic        halt_req,
    input  logic        cpu_phi2,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_we,
    input  logic        cpu_cs,
    input  logic [15:0] diag_address,
    input  logic [7:0]  diag_data,
    input  logic        diag_we,
    input  logic        diag_cs,
    output logic        cpu_rdy,
    output logic        halt_ack,
    output logic        halt_timeout,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    output logic        ram_cs
);

    localparam int EW = $clog2(SETTLE_EDGES + 1);
    localparam logic [EW-1:0] SETTLE_MAX = EW'(SETTLE_EDGES);
    localparam logic [EW-1:0] SETTLE_M1  = EW'(SETTLE_EDGES - 1);
    localparam logic [15:0]   TMO_MAX    = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RUN, REQ, GRANTED, RELEASE} state_t;

    state_t        state, state_next;
    logic          phi2_s1, phi2_s2, phi2_hist, phi2_fall;
    logic [EW-1:0] edge_cnt, edge_next;
    logic [15:0]   tmo_cnt, tmo_next;
    logic          bus_owner, owner_next, rdy_next, flag_next;

    assign phi2_fall = phi2_hist & ~phi2_s2;

    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            phi2_s1      <= 1'b0;
            phi2_s2      <= 1'b0;
            phi2_hist    <= 1'b0;
            state        <= RUN;
            edge_cnt     <= '0;
            tmo_cnt      <= '0;
            bus_owner    <= 1'b0;
            cpu_rdy      <= 1'b1;
            halt_timeout <= 1'b0;
        end else begin
            phi2_s1      <= cpu_phi2;
            phi2_s2      <= phi2_s1;
            phi2_hist    <= phi2_s2;
            state        <= state_next;
            edge_cnt     <= edge_next;
            tmo_cnt      <= tmo_next;
            bus_owner    <= owner_next;
            cpu_rdy      <= rdy_next;
            halt_timeout <= flag_next;
        end
    end

    always_comb begin
        state_next = state;
        edge_next  = edge_cnt;
        tmo_next   = tmo_cnt;
        owner_next = bus_owner;
        rdy_next   = cpu_rdy;
        flag_next  = halt_timeout;
        case (state)
            RUN: begin
                owner_next = 1'b0;
                rdy_next   = 1'b1;
                if (halt_req) begin
                    state_next = REQ;
                    rdy_next   = 1'b0;
                    edge_next  = '0;
                    tmo_next   = '0;
                end
            end
            REQ: begin
                rdy_next = 1'b0;
                if (!halt_req) begin
                    // Abort before grant: the CPU never lost the bus.
                    state_next = RELEASE;
                    tmo_next   = '0;
                end else if (phi2_fall) begin
                    // A real edge wins over a coincident timeout terminal count.
                    tmo_next = '0;
                    if (edge_cnt != SETTLE_MAX) edge_next = edge_cnt + 1'b1;
                    if (edge_cnt >= SETTLE_M1) begin
                        state_next = GRANTED;
                        owner_next = 1'b1;
                    end
                end else if (tmo_cnt == TMO_MAX) begin
                    state_next = GRANTED;
                    owner_next = 1'b1;
                    flag_next  = 1'b1;
                end else begin
                    tmo_next = tmo_cnt + 16'd1;
                end
            end
            GRANTED: begin
                rdy_next   = 1'b0;
                owner_next = 1'b1;
                if (!halt_req) begin
                    state_next = RELEASE;
                    owner_next = 1'b0;
                    tmo_next   = '0;
                end
            end
            RELEASE: begin
                rdy_next   = 1'b0;
                owner_next = 1'b0;
                if (phi2_fall || tmo_cnt == TMO_MAX) begin
                    state_next = RUN;
                    rdy_next   = 1'b1;
                end else begin
                    tmo_next = tmo_cnt + 16'd1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign halt_ack    = bus_owner;
    assign ram_address = bus_owner ? diag_address : cpu_address;
    assign ram_data    = bus_owner ? diag_data    : cpu_data;
    assign ram_we      = bus_owner ? diag_we      : cpu_we;
    assign ram_cs      = bus_owner ? diag_cs      : cpu_cs;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: phi2 runs at fpga_clk/8 from the tick task; expected bus snapshots
// are queued as stimulus is driven and compared when the DUT outputs are sampled.
module tb_cpu_bus_arbiter;

    logic        fpga_clk = 1'b0;
    logic        fpga_reset = 1'b1;
    logic        halt_req = 1'b0;
    logic        cpu_phi2 = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_cs = 1'b0;
    logic [15:0] diag_address = '0;
    logic [7:0]  diag_data = '0;
    logic        diag_we = 1'b0;
    logic        diag_cs = 1'b0;
    logic        cpu_rdy, halt_ack, halt_timeout;
    logic [15:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_we, ram_cs;

    cpu_bus_arbiter #(.SETTLE_EDGES(4), .TIMEOUT_CYCLES(100)) dut (
        .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .halt_req(halt_req), .cpu_phi2(cpu_phi2),
        .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
        .diag_address(diag_address), .diag_data(diag_data), .diag_we(diag_we), .diag_cs(diag_cs),
        .cpu_rdy(cpu_rdy), .halt_ack(halt_ack), .halt_timeout(halt_timeout),
        .ram_address(ram_address), .ram_data(ram_data), .ram_we(ram_we), .ram_cs(ram_cs)
    );

    always #5 fpga_clk = ~fpga_clk;

    typedef struct {
        string       tag;
        logic [28:0] v;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [28:0] act;
    int          tests = 0;
    int          failed = 0;
    int          phi_div = 0;
    int          falls = 0;
    bit          phi2_run = 1'b1;
    bit          ack_seen = 1'b0;

    function automatic logic [28:0] snap();
        return {ram_address, ram_data, ram_we, ram_cs, cpu_rdy, halt_ack, halt_timeout};
    endfunction

    // Reference: bus contents selected by the expected owner, plus expected control outputs.
    function automatic logic [28:0] model(input logic own, input logic rdy, input logic tmo);
        if (own) return {diag_address, diag_data, diag_we, diag_cs, rdy, 1'b1, tmo};
        return {cpu_address, cpu_data, cpu_we, cpu_cs, rdy, 1'b0, tmo};
    endfunction

    function automatic void push(input string tag, input logic own, input logic rdy, input logic tmo);
        exp_t x;
        x.tag = tag;
        x.v   = model(own, rdy, tmo);
        sbq.push_back(x);
    endfunction

    task automatic tick();
        @(negedge fpga_clk);
        if (phi2_run) begin
            phi_div = (phi_div + 1) % 4;
            if (phi_div == 0) begin
                cpu_phi2 = ~cpu_phi2;
                if (!cpu_phi2) falls++;
            end
        end
        ack_seen = ack_seen | halt_ack;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Park three ticks after a phi2 toggle so no detected edge is in flight.
    task automatic align();
        for (int i = 0; i < 16 && phi_div != 3; i++) tick();
    endtask

    task automatic wait_falls(input int n, input string tag);
        for (int i = 0; i < 200 && falls < n; i++) tick();
        if (falls < n) begin
            tests++; failed++;
            $display("FAIL %s: saw %0d phi2 falls, needed %0d", tag, falls, n);
        end
    endtask

    task automatic test_reset();
        fpga_reset = 1'b1;
        ticks(3);
        push("reset_state", 1'b0, 1'b1, 1'b0);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        fpga_reset = 1'b0;
        cpu_address = 16'h1234; cpu_cs = 1'b1; cpu_data = 8'h5A; cpu_we = 1'b1;
        diag_address = 16'hBEEF; diag_data = 8'hA5; diag_we = 1'b0; diag_cs = 1'b1;
        push("cpu_pass", 1'b0, 1'b1, 1'b0);
        ticks(2);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
    endtask

    task automatic test_grant();
        align();
        halt_req = 1'b1; falls = 0;
        push("rdy_fall", 1'b0, 1'b0, 1'b0);
        tick();
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        wait_falls(4, "grant_wait");
        push("pre_grant", 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        push("grant_early", 1'b0, 1'b0, 1'b0);
        ticks(2);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        push("grant", 1'b1, 1'b0, 1'b0);
        ticks(2);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        diag_address = 16'h1357; diag_data = 8'h3C; diag_we = 1'b1;
        push("mux_live", 1'b1, 1'b0, 1'b0);
        #1;
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
    endtask

    task automatic test_release();
        align();
        halt_req = 1'b0; falls = 0;
        cpu_address = 16'h4321; cpu_we = 1'b0;
        push("bus_return", 1'b0, 1'b0, 1'b0);
        tick();
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        wait_falls(1, "release_wait");
        push("rdy_hold", 1'b0, 1'b0, 1'b0);
        tick();
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        push("rdy_rise", 1'b0, 1'b1, 1'b0);
        ticks(3);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
    endtask

    task automatic test_abort();
        align();
        halt_req = 1'b1; falls = 0; ack_seen = 1'b0;
        wait_falls(2, "abort_wait");
        ticks(4);
        halt_req = 1'b0; falls = 0;
        push("abort_noack", 1'b0, 1'b0, 1'b0);
        tick();
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        wait_falls(1, "abort_fall");
        push("abort_resume", 1'b0, 1'b1, 1'b0);
        ticks(4);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        tests++;
        if (ack_seen !== 1'b0) begin failed++; $display("FAIL abort_ack_never: got %b expected 0", ack_seen); end
    endtask

    task automatic test_timeout();
        phi2_run = 1'b0;
        cpu_phi2 = 1'b1;
        ticks(6);
        halt_req = 1'b1;
        // REQ is entered on the first edge; the forced grant lands 101 cycles after that.
        push("tmo_pre", 1'b0, 1'b0, 1'b0);
        ticks(101);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        push("tmo_grant", 1'b1, 1'b0, 1'b1);
        tick();
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        halt_req = 1'b0;
        push("tmo_release", 1'b0, 1'b0, 1'b1);
        tick();
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        for (int i = 0; i < 150 && cpu_rdy !== 1'b1; i++) tick();
        push("tmo_sticky", 1'b0, 1'b1, 1'b1);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        phi2_run = 1'b1;
        ticks(12);
    endtask

    task automatic test_reset_mid_halt();
        align();
        halt_req = 1'b1; falls = 0;
        wait_falls(4, "grant2_wait");
        ticks(4);
        push("grant_flag_kept", 1'b1, 1'b0, 1'b1);
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        fpga_reset = 1'b1; halt_req = 1'b0;
        push("reset_mid", 1'b0, 1'b1, 1'b0);
        tick();
        e = sbq.pop_front(); act = snap(); tests++;
        if (act !== e.v) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, act, e.v); end
        fpga_reset = 1'b0;
        ticks(2);
    endtask

    initial begin
        test_reset();
        test_grant();
        test_release();
        test_abort();
        test_timeout();
        test_reset_mid_halt();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
